// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder cell is stepped LSB first
// over WIDTH cycles, with a registered carry and a start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 of the result is at the LSB.
  assign w_res_next = WIDTH'({w_fa_sum, r_res_sh} >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            sum     <= w_res_next;
            cout    <= w_fa_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1: stimulus pushes
// expected {cout,sum}, per-instance monitors pop and compare on each done pulse.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: one comparison per done pulse, plus busy/done exclusivity every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy_done_excl8", 64'(busy8 & done8), 64'd0);
      if (done8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done8: got sum=0x%0h cout=%0b expected no done", sum8, cout8);
        end else begin
          logic [8:0] e;
          e = q8.pop_front();
          chk("result8", 64'({cout8, sum8}), 64'(e));
          if (verbose) $display("w8 result sum=0x%02h cout=%0b exp=0x%03h", sum8, cout8, e);
        end
      end
      chk("busy_done_excl1", 64'(busy1 & done1), 64'd0);
      if (done1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done1: got sum=%0b cout=%0b expected no done", sum1, cout1);
        end else begin
          logic [1:0] e;
          e = q1.pop_front();
          chk("result1", 64'({cout1, sum1}), 64'(e));
        end
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
  endtask

  task automatic issue1(input logic a, input logic b, input logic c);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
  endtask

  // Advance negedge by negedge until done is seen; n = cycles waited, bc = busy cycles.
  task automatic wait_done8(input int bound, output int n, output int bc);
    bit seen;
    n = 0; bc = 0; seen = 1'b0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (busy8) bc++;
      if (done8) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout8: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic wait_done1(input int bound);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (done1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout1: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n, bc;
    issue8(a, b, c);
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8(30, n, bc);
    chk("latency8", 64'(n), 64'd9);
    chk("busy_cycles8", 64'(bc), 64'd8);
    @(negedge clk);
  endtask

  initial begin
    int n, bc, dcnt, g;
    logic [7:0] ta [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb [4] = '{8'h3C, 8'h01, 8'hFF, 8'h00};
    logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_sum8",  64'(sum8),  64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_sum1",  64'(sum1),  64'd0);

    // Directed vectors: 0x96/0, 0x00/1, 0xFF/1, 0x01/0
    for (int i = 0; i < 4; i++) run8(ta[i], tb[i], tc[i]);

    // start and operand churn while RUN must not disturb 0x12+0x34
    issue8(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = ~a8; b8 = ~b8;
      end
      if (i == 5) chk("hold_sum_during_run", 64'(sum8), 64'h01);
    end
    start8 = 1'b0;
    wait_done8(10, n, bc);
    chk("ignored_start_latency", 64'(n), 64'd1);
    repeat (12) @(negedge clk);

    // Back-to-back with start held high
    issue8(8'h10, 8'h20, 1'b0);
    wait_done8(12, n, bc);
    issue8(8'h80, 8'h80, 1'b0);
    n = 0; dcnt = 0;
    while (n < 12 && dcnt == 0) begin
      @(negedge clk);
      n++;
      chk("b2b_busy_or_done", 64'(busy8 | done8), 64'd1);
      if (done8) dcnt++;
    end
    chk("b2b_done_gap", 64'(n), 64'd9);
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Abort with reset at the 4th RUN edge
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum",  64'(sum8),  64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    run8(8'h01, 8'h01, 1'b0);

    // Randomised operations, WIDTH=8, gaps 0..3
    verbose = 1'b0;
    issue8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 start8 = 1'b0;
      wait_done8(12, n, bc);
      if (i == 999) break;
      g = $urandom_range(0, 3);
      repeat (g) @(negedge clk);
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Randomised operations, WIDTH=1, gaps 0..3
    @(negedge clk);
    issue1(1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 start1 = 1'b0;
      wait_done1(4);
      if (i == 999) break;
      g = $urandom_range(0, 3);
      repeat (g) @(negedge clk);
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue8_drained", 64'(q8.size()), 64'd0);
    chk("queue1_drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
